imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Registered, handshaked immediate generator for the ID stage of the pipelined core.
//  Per instruction it produces:
//   - the sign-extended immediate,
//   - its format code,
//   - a legality flag,
//   - the PC-relative target pc+imm.
//  Sits between the IF/ID register and the register-file read/EX issue.
//  Supports RV32/RV64 via XLEN.
//  A 2-entry skid buffer gives full throughput under backpressure.
// PARAMETERS
//  XLEN      32  datapath width; 32 or 64 only (elaboration error otherwise)
//  SKID_EN   1   1: 2-entry skid buffer (in_ready registered);
//                0: single stage, in_ready = !out_valid | out_ready
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  flush        in   1     sync kill of all held entries (branch mispredict/trap)
//  in_valid     in   1     in_instr/in_pc valid
//  in_ready     out  1     block can accept this cycle
//  in_instr     in   32    raw instruction
//  in_pc        in   XLEN  PC of in_instr
//  out_valid    out  1     output entry valid
//  out_ready    in   1     consumer accepts this cycle
//  out_imm      out  XLEN  immediate, sign-extended to XLEN
//  out_fmt      out  3     IMM_FMT_{R,I,S,B,U,J}
//  out_target   out  XLEN  out_pc + out_imm, mod 2^XLEN
//  out_illegal  out  1     instr[1:0]!=2'b11 or opcode[6:2] not an RV32I/RV64I major opcode
// BEHAVIOUR
//  - Reset (async, immediate):
//      out_valid=0, out_imm/out_target/out_fmt/out_illegal=0, skid empty.
//      in_ready=1 from the first edge after rst deasserts.
//  - Transfer: occurs when valid&ready are both high on a rising edge.
//  - Latency: 1 cycle from input transfer to out_valid; no combinational in->out path.
//  - Immediate decode, by opcode[6:2]:
//      STORE          -> S:  sext{i[31:25],i[11:7]}
//      BRANCH         -> B:  sext{i[31],i[7],i[30:25],i[11:8],0}
//      LUI/AUIPC      -> U:  sext{i[31:12],12'b0}  (bit31 extends for XLEN=64)
//      JAL            -> J:  sext{i[31],i[19:12],i[20],i[30:21],0}
//      OP/OP-32       -> R:  imm=0
//      OP-IMM/LOAD/JALR/SYSTEM/MISC-MEM/OP-IMM-32 -> I: sext i[31:20]
//      anything else, or illegal -> fmt=R, imm=0, out_illegal=1
//  - Target: computed for every entry; wrap-around modulo 2^XLEN, no overflow flag.
//  - Skid (SKID_EN=1):
//      main entry drives the outputs; when main is held (out_valid & !out_ready)
//        and an input transfers, the input goes to skid.
//      in_ready = !skid_full (registered).
//      On main drain, skid moves to main in the same edge.
//      Order is strictly FIFO.
//  - Simultaneous drain+fill: with main valid and out_ready=1, a new input
//      loads main directly (no bubble).
//  - flush: on the edge where flush=1, both entries are invalidated.
//      Any input offered that cycle is dropped.
//      Next cycle: out_valid=0, in_ready=1.
//      flush has priority over every other event.
//  - Reset mid-operation: all entries discarded at once; no partial output.
//  - While out_valid=1 and out_ready=0, every out_* signal is held stable.
// STRUCTURE
//  - Shared package riscv_def.v holds:
//      OP_* opcode codes, IMM_FMT_* 3-bit encodings,
//      XLEN default, OPCODE field range.
//  - Sub-module imm_decode: combinational instr -> {imm, fmt, illegal}, parametrised by XLEN.
//  - imm_gen_pipe: instantiates imm_decode once at the input, then adds the target adder,
//      skid/main registers, and handshake control.
// TESTING
//  1. XLEN=32, pc=0x1000, 0xFFF00093 (addi x1,x0,-1)
//       -> imm=0xFFFFFFFF, fmt=I, target=0x00000FFF, illegal=0, one cycle later.
//  2. 0xFE112E23 (sw x1,-4(x2))
//       -> imm=0xFFFFFFFC, fmt=S.
//     0xFE000CE3 (beq -8) at pc=0x100
//       -> imm=0xFFFFFFF8, fmt=B, target=0x000000F8.
//  3. XLEN=64, 0x800000B7 (lui x1,0x80000)
//       -> imm=0xFFFFFFFF80000000, fmt=U.
//     0x00000013 with [1:0]=2'b00 (0x00000010)
//       -> illegal=1, imm=0.
//  4. Backpressure: out_ready=0; offer 3 back-to-back instrs
//       -> exactly 2 accepted, in_ready=0 on 3rd.
//     Raise out_ready -> all 3 emerge in order, no duplicates, no bubbles.
//  5. Flush with both entries full and in_valid=1
//       -> next cycle out_valid=0, in_ready=1, flushed-cycle input never appears.
//  6. Assert rst mid-stream (async, between edges)
//       -> out_valid=0 immediately.
//     After release, 0x0000006F (jal x0,0) at pc=0x80000000 (XLEN=32) -> target=0x80000000.
//     Also pc=0xFFFFFFFC with imm=+8 -> target=0x00000004 (wrap).

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared RISC-V decode constants for the ID-stage immediate generator:
// major opcodes (instr[6:2]), immediate format codes and field positions.
package imm_gen_pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int OPC_HI   = 6;
    localparam int OPC_LO   = 2;

    typedef enum logic [4:0] {
        OP_LOAD      = 5'b00000,
        OP_MISC_MEM  = 5'b00011,
        OP_OP_IMM    = 5'b00100,
        OP_AUIPC     = 5'b00101,
        OP_OP_IMM_32 = 5'b00110,
        OP_STORE     = 5'b01000,
        OP_OP        = 5'b01100,
        OP_LUI       = 5'b01101,
        OP_OP_32     = 5'b01110,
        OP_BRANCH    = 5'b11000,
        OP_JALR      = 5'b11001,
        OP_JAL       = 5'b11011,
        OP_SYSTEM    = 5'b11100
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_FMT_R = 3'd0,
        IMM_FMT_I = 3'd1,
        IMM_FMT_S = 3'd2,
        IMM_FMT_B = 3'd3,
        IMM_FMT_U = 3'd4,
        IMM_FMT_J = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// Combinational immediate decoder: raw instruction -> sign-extended
// immediate, format code and legality flag.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    // Built as a signed 32-bit value so the final width cast sign-extends for RV64.
    logic signed [31:0] imm32;

    always_comb begin
        imm32     = '0;
        fmt_o     = IMM_FMT_R;
        illegal_o = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (opcode_e'(instr_i[OPC_HI:OPC_LO]))
                OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_OP_IMM_32, OP_JALR, OP_SYSTEM: begin
                    fmt_o = IMM_FMT_I;
                    imm32 = 32'($signed(instr_i[31:20]));
                end
                OP_STORE: begin
                    fmt_o = IMM_FMT_S;
                    imm32 = 32'($signed({instr_i[31:25], instr_i[11:7]}));
                end
                OP_BRANCH: begin
                    fmt_o = IMM_FMT_B;
                    imm32 = 32'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                         instr_i[11:8], 1'b0}));
                end
                OP_LUI, OP_AUIPC: begin
                    fmt_o = IMM_FMT_U;
                    imm32 = {instr_i[31:12], 12'b0};
                end
                OP_JAL: begin
                    fmt_o = IMM_FMT_J;
                    imm32 = 32'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                         instr_i[30:21], 1'b0}));
                end
                OP_OP, OP_OP_32: fmt_o = IMM_FMT_R;
                default:         illegal_o = 1'b1;
            endcase
        end
    end

    assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked ID-stage immediate generator with optional
// 2-entry skid buffer (main entry drives outputs, skid catches one extra).
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_ill;
    entry_t          in_ent;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_ill)
    );

    assign in_ent = '{imm: dec_imm, tgt: in_pc + dec_imm, fmt: dec_fmt, ill: dec_ill};

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic   rdy_q, rdy_d;
    logic   acc, drain;

    assign in_ready = SKID_EN ? rdy_q : (!main_vld_q || out_ready);
    assign acc      = in_valid && in_ready;
    assign drain    = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || drain) begin
            // Main frees up: skid (older) takes priority, new input backfills.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = acc;
                if (acc) skid_d = in_ent;
            end else begin
                main_vld_d = acc;
                if (acc) main_d = in_ent;
            end
        end else if (acc) begin
            skid_vld_d = 1'b1;
            skid_d     = in_ent;
        end
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign out_valid   = main_vld_q;
    assign out_imm     = main_q.imm;
    assign out_target  = main_q.tgt;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: RV32 and RV64 instances driven in lockstep, checked
// against an arithmetic reference model of the immediate rules.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, pc32;
    logic [63:0] pc64;

    logic        r32, v32, ill32, r64, v64, ill64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt32, fmt64;

    int   errors = 0;
    int   checks = 0;
    exp_t q32[$];
    exp_t q64[$];
    logic hold_pend = 1'b0;
    logic [31:0] snap_imm, snap_tgt;
    logic [2:0]  snap_fmt;
    logic        snap_ill;

    logic [6:0] op_tab [18] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B,
                                7'h63, 7'h67, 7'h6F, 7'h73, 7'h0B, 7'h2F, 7'h53, 7'h7F, 7'h12};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_instr(in_instr), .in_pc(pc32), .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32), .out_illegal(ill32));

    imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_instr(in_instr), .in_pc(pc64), .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64), .out_illegal(ill64));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Immediate value from field weights, then wrapped to the datapath width.
    function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc, input int xl);
        exp_t        e;
        longint      u, v;
        logic [63:0] m;
        u = longint'(i);
        v = 0;
        e.fmt = F_R;
        e.ill = 1'b0;
        if (i[1:0] != 2'b11) e.ill = 1'b1;
        else case (i[6:0])
            7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73: begin
                e.fmt = F_I; v = u >> 20; if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                e.fmt = F_S; v = ((u >> 25) * 32) + ((u >> 7) & 31); if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                e.fmt = F_B;
                v = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: begin
                e.fmt = F_U; v = u & 64'shFFFFF000; if (v >= 64'sh80000000) v -= 64'sh100000000;
            end
            7'h6F: begin
                e.fmt = F_J;
                v = ((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            7'h33, 7'h3B: e.fmt = F_R;
            default: e.ill = 1'b1;
        endcase
        m = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e.imm = v & m;
        e.tgt = (pc + v) & m;
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        r[6:0] = op_tab[$urandom_range(0, 17)];
        return r;
    endfunction

    // One cycle of stimulus; expected results enter the scoreboard on acceptance.
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = v; in_instr = ins; pc32 = pc[31:0]; pc64 = pc; out_ready = ordy; flush = fl;
        #1;
        if (fl) begin
            q32.delete();
            q64.delete();
        end else begin
            if (v && r32) q32.push_back(model(ins, {32'b0, pc[31:0]}, 32));
            if (v && r64) q64.push_back(model(ins, pc, 64));
        end
    endtask

    // Monitor: pops and compares whenever an output is consumed; checks hold stability.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            if (hold_pend) begin
                chk("hold_valid", {63'b0, v32}, 64'd1);
                chk("hold_data", {imm32, tgt32}, {snap_imm, snap_tgt});
                chk("hold_fmt_ill", {60'b0, fmt32, ill32}, {60'b0, snap_fmt, snap_ill});
            end
            hold_pend = v32 && !out_ready && !flush;
            snap_imm = imm32; snap_tgt = tgt32; snap_fmt = fmt32; snap_ill = ill32;
            if (!flush && v32 && out_ready) begin
                if (q32.size() == 0) chk("mon32_unexpected_out", 64'd1, 64'd0);
                else begin
                    e = q32.pop_front();
                    chk("mon32_imm", {32'b0, imm32}, e.imm);
                    chk("mon32_tgt", {32'b0, tgt32}, e.tgt);
                    chk("mon32_fmt", {61'b0, fmt32}, {61'b0, e.fmt});
                    chk("mon32_ill", {63'b0, ill32}, {63'b0, e.ill});
                end
            end
            if (!flush && v64 && out_ready) begin
                if (q64.size() == 0) chk("mon64_unexpected_out", 64'd1, 64'd0);
                else begin
                    e = q64.pop_front();
                    chk("mon64_imm", imm64, e.imm);
                    chk("mon64_tgt", tgt64, e.tgt);
                    chk("mon64_fmt", {61'b0, fmt64}, {61'b0, e.fmt});
                    chk("mon64_ill", {63'b0, ill64}, {63'b0, e.ill});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; pc32 = '0; pc64 = '0;
        @(posedge clk); #2;
        chk("rst_valid32", {63'b0, v32}, 64'd0);
        chk("rst_valid64", {63'b0, v64}, 64'd0);
        chk("rst_imm_tgt", {imm32, tgt32}, 64'd0);
        chk("rst_fmt_ill", {60'b0, fmt32, ill32}, 64'd0);
        @(negedge clk); #3 rst = 1'b0;
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("rst_in_ready", {63'b0, r32}, 64'd1);

        // addi x1,x0,-1 at 0x1000
        step(1'b1, 32'hFFF00093, 64'h1000, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("addi_latency", {63'b0, v32}, 64'd1);
        chk("addi_imm", {32'b0, imm32}, 64'hFFFFFFFF);
        chk("addi_fmt", {61'b0, fmt32}, {61'b0, F_I});
        chk("addi_tgt", {32'b0, tgt32}, 64'h00000FFF);
        chk("addi_ill", {63'b0, ill32}, 64'd0);

        step(1'b1, 32'hFE112E23, 64'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("sw_imm", {32'b0, imm32}, 64'hFFFFFFFC);
        chk("sw_fmt", {61'b0, fmt32}, {61'b0, F_S});
        step(1'b1, 32'hFE000CE3, 64'h100, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("beq_imm", {32'b0, imm32}, 64'hFFFFFFF8);
        chk("beq_fmt", {61'b0, fmt32}, {61'b0, F_B});
        chk("beq_tgt", {32'b0, tgt32}, 64'h000000F8);

        step(1'b1, 32'h800000B7, 64'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
        chk("lui64_fmt", {61'b0, fmt64}, {61'b0, F_U});
        step(1'b1, 32'h00000010, 64'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("illegal64_flag", {63'b0, ill64}, 64'd1);
        chk("illegal64_imm", imm64, 64'd0);

        // Backpressure: two accepted, third stalls, then all drain without bubbles.
        step(1'b1, 32'h00100093, 64'h10, 1'b0, 1'b0);
        chk("bp_ready1", {63'b0, r32}, 64'd1);
        step(1'b1, 32'h00200113, 64'h14, 1'b0, 1'b0);
        chk("bp_ready2", {63'b0, r32}, 64'd1);
        step(1'b1, 32'h00300193, 64'h18, 1'b0, 1'b0);
        chk("bp_ready3", {63'b0, r32}, 64'd0);
        step(1'b1, 32'h00300193, 64'h18, 1'b1, 1'b0);
        chk("bp_out_a", {63'b0, v32}, 64'd1);
        step(1'b1, 32'h00300193, 64'h18, 1'b1, 1'b0);
        chk("bp_out_b", {63'b0, v32}, 64'd1);
        chk("bp_ready_again", {63'b0, r32}, 64'd1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("bp_out_c", {63'b0, v32}, 64'd1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("bp_empty", {63'b0, v32}, 64'd0);

        // Flush with both entries full and an input offered.
        step(1'b1, 32'h00400213, 64'h20, 1'b0, 1'b0);
        step(1'b1, 32'h00500293, 64'h24, 1'b0, 1'b0);
        step(1'b1, 32'h00600313, 64'h28, 1'b0, 1'b1);
        chk("flush_full_before", {63'b0, r32}, 64'd0);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        chk("flush_valid", {63'b0, v32}, 64'd0);
        chk("flush_ready", {63'b0, r32}, 64'd1);
        // Flush while input would otherwise be accepted into skid.
        step(1'b1, 32'h00700393, 64'h30, 1'b0, 1'b0);
        step(1'b1, 32'h00800413, 64'h34, 1'b0, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("flush2_valid", {63'b0, v32 | v64}, 64'd0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("flush2_no_ghost", {63'b0, v32}, 64'd0);

        // Asynchronous reset mid-stream.
        step(1'b1, 32'h00900493, 64'h40, 1'b0, 1'b0);
        step(1'b1, 32'h00A00513, 64'h44, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid32", {63'b0, v32}, 64'd0);
        chk("async_rst_valid64", {63'b0, v64}, 64'd0);
        q32.delete(); q64.delete(); hold_pend = 1'b0;
        in_valid = 1'b0;
        #4 rst = 1'b0;
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        step(1'b1, 32'h0000006F, 64'h80000000, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("jal_tgt", {32'b0, tgt32}, 64'h80000000);
        chk("jal_fmt", {61'b0, fmt32}, {61'b0, F_J});
        step(1'b1, 32'h00800013, 64'hFFFFFFFC, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("wrap_tgt32", {32'b0, tgt32}, 64'h00000004);
        chk("wrap_tgt64", tgt64, 64'h0000000100000004);

        // Randomized traffic with backpressure and occasional flushes.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, rnd_instr(), {$urandom, $urandom},
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        end
        for (int n = 0; n < 4; n++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("drain32_empty", 64'(q32.size()), 64'd0);
        chk("drain64_empty", 64'(q64.size()), 64'd0);
        chk("drain_valid", {63'b0, v32}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
